// File: rtl/scarv_cop_pkg.sv
// -----------------------------------------------------------------------------
// scarv_cop_pkg
// Shared constants and types for the SCARV crypto ISE coprocessor decoder.
//
// Encoding layout (fields overlap; which ones carry meaning depends on class):
//   [31:29] class       [28:25] subclass     [24:22] pack width
//   [22:19] crs2        [18:15] crs1         [14:11] crs3 / crd2
//   [10:7]  crd / crd1  [11:7]  rd           [19:15] rs1
//   [24:14] imm (sign-extended to 32 bits)
//   [12]    wb_h        [11]    wb_b         [6:0]   major opcode
// -----------------------------------------------------------------------------
package scarv_cop_pkg;

  localparam logic [6:0] SCARV_COP_OPCODE = 7'b0101011;

  // Instruction classes. Class 7 is unallocated and decodes as a bad opcode.
  localparam logic [2:0] SCARV_COP_CLASS_PACKED_ARITH = 3'd0;
  localparam logic [2:0] SCARV_COP_CLASS_TWIDDLE      = 3'd1;
  localparam logic [2:0] SCARV_COP_CLASS_LOADSTORE    = 3'd2;
  localparam logic [2:0] SCARV_COP_CLASS_RANDOM       = 3'd3;
  localparam logic [2:0] SCARV_COP_CLASS_MOVE         = 3'd4;
  localparam logic [2:0] SCARV_COP_CLASS_MP           = 3'd5;
  localparam logic [2:0] SCARV_COP_CLASS_BITWISE      = 3'd6;

  // Packed arithmetic subclasses.
  localparam logic [3:0] SCARV_COP_SCLASS_ADD_PX = 4'd0;
  localparam logic [3:0] SCARV_COP_SCLASS_SUB_PX = 4'd1;
  localparam logic [3:0] SCARV_COP_SCLASS_MUL_PX = 4'd2;
  localparam logic [3:0] SCARV_COP_SCLASS_SLL_PX = 4'd3;
  localparam logic [3:0] SCARV_COP_SCLASS_SRL_PX = 4'd4;

  // Load/store subclasses; the last two are scatter/gather.
  localparam logic [3:0] SCARV_COP_SCLASS_LW        = 4'd0;
  localparam logic [3:0] SCARV_COP_SCLASS_LH        = 4'd1;
  localparam logic [3:0] SCARV_COP_SCLASS_LB        = 4'd2;
  localparam logic [3:0] SCARV_COP_SCLASS_SW        = 4'd3;
  localparam logic [3:0] SCARV_COP_SCLASS_SH        = 4'd4;
  localparam logic [3:0] SCARV_COP_SCLASS_SB        = 4'd5;
  localparam logic [3:0] SCARV_COP_SCLASS_SCATTER_B = 4'd6;
  localparam logic [3:0] SCARV_COP_SCLASS_GATHER_B  = 4'd7;

  // MCCR feature-enable bit indices.
  localparam int SCARV_COP_MCCR_R   = 0;
  localparam int SCARV_COP_MCCR_MP  = 1;
  localparam int SCARV_COP_MCCR_SG  = 2;
  localparam int SCARV_COP_MCCR_P32 = 3;
  localparam int SCARV_COP_MCCR_P16 = 4;
  localparam int SCARV_COP_MCCR_P8  = 5;
  localparam int SCARV_COP_MCCR_P4  = 6;
  localparam int SCARV_COP_MCCR_P2  = 7;

  // Pack-width codes; codes 0..PW_NUM-1 map onto consecutive MCCR bits
  // starting at P32, codes above are reserved.
  localparam logic [2:0] SCARV_COP_PW_32  = 3'd0;
  localparam logic [2:0] SCARV_COP_PW_16  = 3'd1;
  localparam logic [2:0] SCARV_COP_PW_8   = 3'd2;
  localparam logic [2:0] SCARV_COP_PW_4   = 3'd3;
  localparam logic [2:0] SCARV_COP_PW_2   = 3'd4;
  localparam int         SCARV_COP_PW_NUM = 5;

  // Exception cause codes.
  localparam logic [1:0] SCARV_COP_CAUSE_NONE       = 2'd0;
  localparam logic [1:0] SCARV_COP_CAUSE_BAD_OPCODE = 2'd1;
  localparam logic [1:0] SCARV_COP_CAUSE_CLASS_DIS  = 2'd2;
  localparam logic [1:0] SCARV_COP_CAUSE_PW_DIS     = 2'd3;

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  subclass;
    logic [2:0]  pw;
    logic [3:0]  crs1;
    logic [3:0]  crs2;
    logic [3:0]  crs3;
    logic [3:0]  crd;
    logic [3:0]  crd1;
    logic [3:0]  crd2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic        wb_h;
    logic        wb_b;
  } scarv_cop_fields_t;

  // Number of allocated subclasses per class; 0 marks an unallocated class.
  function automatic logic [4:0] scarv_cop_num_subclasses(input logic [2:0] cls);
    case (cls)
      SCARV_COP_CLASS_PACKED_ARITH: return 5'd5;
      SCARV_COP_CLASS_TWIDDLE:      return 5'd4;
      SCARV_COP_CLASS_LOADSTORE:    return 5'd8;
      SCARV_COP_CLASS_RANDOM:       return 5'd3;
      SCARV_COP_CLASS_MOVE:         return 5'd4;
      SCARV_COP_CLASS_MP:           return 5'd8;
      SCARV_COP_CLASS_BITWISE:      return 5'd8;
      default:                      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/scarv_cop_idecode.sv
// -----------------------------------------------------------------------------
// scarv_cop_idecode
// Combinational field extraction for one coprocessor instruction. It performs
// no feature gating; it only reports whether the encoding is allocated.
//
// Ports:
//   encoded    in  32  raw instruction
//   fields     out     extracted class/subclass/pw/register/immediate fields
//   bad_opcode out 1   wrong major opcode, unallocated class or subclass
// -----------------------------------------------------------------------------
module scarv_cop_idecode
  import scarv_cop_pkg::*;
(
  input  logic [31:0]       encoded,
  output scarv_cop_fields_t fields,
  output logic              bad_opcode
);

  always_comb begin
    fields          = '0;
    fields.cls      = encoded[31:29];
    fields.subclass = encoded[28:25];
    fields.pw       = encoded[24:22];
    fields.crs1     = encoded[18:15];
    fields.crs2     = encoded[22:19];
    fields.crs3     = encoded[14:11];
    fields.crd      = encoded[10:7];
    fields.crd1     = encoded[10:7];
    fields.crd2     = encoded[14:11];
    fields.rd       = encoded[11:7];
    fields.rs1      = encoded[19:15];
    fields.imm      = {{21{encoded[24]}}, encoded[24:14]};
    fields.wb_h     = encoded[12];
    fields.wb_b     = encoded[11];
  end

  assign bad_opcode = (encoded[6:0] != SCARV_COP_OPCODE) ||
                      ({1'b0, encoded[28:25]} >= scarv_cop_num_subclasses(encoded[31:29]));

endmodule

// File: rtl/scarv_cop_dec_stage.sv
// -----------------------------------------------------------------------------
// scarv_cop_dec_stage
// Registered decode stage: a DEPTH-entry FIFO of raw encodings, a decoder on
// the FIFO head, and an output register under a valid/ready handshake.
// Exceptions are qualified by the feature enables (FEAT_MASK & mccr) sampled
// when the head is loaded into the output register.
//
// Ports:
//   g_clk, g_resetn                 clock, async active-low reset
//   cpu_insn_req_valid/ready        instruction offer handshake
//   cpu_insn_req_encoded [31:0]     raw instruction
//   flush                           drop all buffered and decoded state
//   mccr [7:0]                      runtime feature enables
//   dec_valid/dec_ready             output handshake
//   dec_class/subclass/pw           decoded class fields
//   dec_crs1..3, dec_crd/crd1/crd2  COP register fields
//   dec_rd, dec_rs1                 GPR fields
//   dec_imm [31:0]                  sign-extended immediate
//   dec_wb_h, dec_wb_b              halfword / byte index
//   dec_exception, dec_cause [1:0]  illegal-instruction flag and cause
//   dec_encoded [31:0]              raw encoding passthrough
//   fifo_count                      FIFO occupancy
// -----------------------------------------------------------------------------
module scarv_cop_dec_stage #(
  parameter int         DEPTH     = 2,
  parameter logic [7:0] FEAT_MASK = 8'hFF
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     cpu_insn_req_valid,
  output logic                     cpu_insn_req_ready,
  input  logic [31:0]              cpu_insn_req_encoded,
  input  logic                     flush,
  input  logic [7:0]               mccr,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [2:0]               dec_class,
  output logic [3:0]               dec_subclass,
  output logic [2:0]               dec_pw,
  output logic [3:0]               dec_crs1,
  output logic [3:0]               dec_crs2,
  output logic [3:0]               dec_crs3,
  output logic [3:0]               dec_crd,
  output logic [3:0]               dec_crd1,
  output logic [3:0]               dec_crd2,
  output logic [4:0]               dec_rd,
  output logic [4:0]               dec_rs1,
  output logic [31:0]              dec_imm,
  output logic                     dec_wb_h,
  output logic                     dec_wb_b,
  output logic                     dec_exception,
  output logic [1:0]               dec_cause,
  output logic [31:0]              dec_encoded,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  import scarv_cop_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // FIFO state
  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Output register
  logic              dec_valid_reg;
  scarv_cop_fields_t dec_fields_reg;
  logic [1:0]        dec_cause_reg;
  logic [31:0]       dec_encoded_reg;

  // Head decode
  logic [31:0]       head_encoded;
  scarv_cop_fields_t head_fields;
  logic              head_bad;
  logic [1:0]        head_cause;
  logic [7:0]        en;
  logic [7:0]        pw_en;
  logic              class_dis;

  logic push;
  logic pop;

  assign cpu_insn_req_ready = (count_reg != CNT_FULL);
  assign push = cpu_insn_req_valid && cpu_insn_req_ready;
  assign pop  = (count_reg != '0) && (!dec_valid_reg || dec_ready);

  assign head_encoded = fifo_mem[rd_ptr_reg];

  scarv_cop_idecode u_idecode (
    .encoded    (head_encoded),
    .fields     (head_fields),
    .bad_opcode (head_bad)
  );

  assign en = FEAT_MASK & mccr;

  // One enable bit per pack-width code; reserved codes are never enabled,
  // which makes them fault regardless of mccr.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pw_en
    if (gi < SCARV_COP_PW_NUM) begin : g_legal
      assign pw_en[gi] = en[SCARV_COP_MCCR_P32 + gi];
    end else begin : g_reserved
      assign pw_en[gi] = 1'b0;
    end
  end

  always_comb begin
    class_dis = 1'b0;
    case (head_fields.cls)
      SCARV_COP_CLASS_RANDOM:    class_dis = !en[SCARV_COP_MCCR_R];
      SCARV_COP_CLASS_MP:        class_dis = !en[SCARV_COP_MCCR_MP];
      SCARV_COP_CLASS_LOADSTORE: class_dis = !en[SCARV_COP_MCCR_SG] &&
          ((head_fields.subclass == SCARV_COP_SCLASS_SCATTER_B) ||
           (head_fields.subclass == SCARV_COP_SCLASS_GATHER_B));
      default:                   class_dis = 1'b0;
    endcase
  end

  always_comb begin
    head_cause = SCARV_COP_CAUSE_NONE;
    if (head_bad) begin
      head_cause = SCARV_COP_CAUSE_BAD_OPCODE;
    end else if (class_dis) begin
      head_cause = SCARV_COP_CAUSE_CLASS_DIS;
    end else if ((head_fields.cls == SCARV_COP_CLASS_PACKED_ARITH) && !pw_en[head_fields.pw]) begin
      head_cause = SCARV_COP_CAUSE_PW_DIS;
    end
  end

  // FIFO storage has no reset; entries are only ever read behind the pointers.
  always_ff @(posedge g_clk) begin
    if (push && !flush) begin
      fifo_mem[wr_ptr_reg] <= cpu_insn_req_encoded;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      dec_valid_reg   <= 1'b0;
      dec_fields_reg  <= '0;
      dec_cause_reg   <= SCARV_COP_CAUSE_NONE;
      dec_encoded_reg <= '0;
    end else if (flush) begin
      // Decoded data is left stale; dec_valid=0 makes it meaningless.
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      dec_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase

      if (pop) begin
        dec_valid_reg   <= 1'b1;
        dec_fields_reg  <= head_fields;
        dec_cause_reg   <= head_cause;
        dec_encoded_reg <= head_encoded;
      end else if (dec_ready) begin
        dec_valid_reg <= 1'b0;
      end
    end
  end

  assign fifo_count    = count_reg;
  assign dec_valid     = dec_valid_reg;
  assign dec_class     = dec_fields_reg.cls;
  assign dec_subclass  = dec_fields_reg.subclass;
  assign dec_pw        = dec_fields_reg.pw;
  assign dec_crs1      = dec_fields_reg.crs1;
  assign dec_crs2      = dec_fields_reg.crs2;
  assign dec_crs3      = dec_fields_reg.crs3;
  assign dec_crd       = dec_fields_reg.crd;
  assign dec_crd1      = dec_fields_reg.crd1;
  assign dec_crd2      = dec_fields_reg.crd2;
  assign dec_rd        = dec_fields_reg.rd;
  assign dec_rs1       = dec_fields_reg.rs1;
  assign dec_imm       = dec_fields_reg.imm;
  assign dec_wb_h      = dec_fields_reg.wb_h;
  assign dec_wb_b      = dec_fields_reg.wb_b;
  assign dec_cause     = dec_cause_reg;
  assign dec_exception = (dec_cause_reg != SCARV_COP_CAUSE_NONE);
  assign dec_encoded   = dec_encoded_reg;

endmodule

// File: tb/tb_scarv_cop_dec_stage.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_dec_stage
// Directed bench for scarv_cop_dec_stage with DEPTH=2 and FEAT_MASK=8'hFF.
// Instructions are built with mk(): {class, subclass, pw, mid[14:0], opcode}.
// -----------------------------------------------------------------------------
module tb_scarv_cop_dec_stage;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        cpu_insn_req_valid = 1'b0;
  logic        cpu_insn_req_ready;
  logic [31:0] cpu_insn_req_encoded = '0;
  logic        flush = 1'b0;
  logic [7:0]  mccr = 8'hFF;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [2:0]  dec_class;
  logic [3:0]  dec_subclass;
  logic [2:0]  dec_pw;
  logic [3:0]  dec_crs1, dec_crs2, dec_crs3, dec_crd, dec_crd1, dec_crd2;
  logic [4:0]  dec_rd, dec_rs1;
  logic [31:0] dec_imm;
  logic        dec_wb_h, dec_wb_b, dec_exception;
  logic [1:0]  dec_cause;
  logic [31:0] dec_encoded;
  logic [1:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  scarv_cop_dec_stage #(.DEPTH(2), .FEAT_MASK(8'hFF)) dut (
    .g_clk                (g_clk),
    .g_resetn             (g_resetn),
    .cpu_insn_req_valid   (cpu_insn_req_valid),
    .cpu_insn_req_ready   (cpu_insn_req_ready),
    .cpu_insn_req_encoded (cpu_insn_req_encoded),
    .flush                (flush),
    .mccr                 (mccr),
    .dec_valid            (dec_valid),
    .dec_ready            (dec_ready),
    .dec_class            (dec_class),
    .dec_subclass         (dec_subclass),
    .dec_pw               (dec_pw),
    .dec_crs1             (dec_crs1),
    .dec_crs2             (dec_crs2),
    .dec_crs3             (dec_crs3),
    .dec_crd              (dec_crd),
    .dec_crd1             (dec_crd1),
    .dec_crd2             (dec_crd2),
    .dec_rd               (dec_rd),
    .dec_rs1              (dec_rs1),
    .dec_imm              (dec_imm),
    .dec_wb_h             (dec_wb_h),
    .dec_wb_b             (dec_wb_b),
    .dec_exception        (dec_exception),
    .dec_cause            (dec_cause),
    .dec_encoded          (dec_encoded),
    .fifo_count           (fifo_count)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] mk(input logic [2:0] cls, input logic [3:0] sub,
                                     input logic [2:0] pw, input logic [14:0] mid);
    return {cls, sub, pw, mid, 7'b0101011};
  endfunction

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({dec_valid, fifo_count, cpu_insn_req_ready} !== {1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_ctrl got valid/count/ready=%b/%0d/%b want 0/0/1", dec_valid, fifo_count, cpu_insn_req_ready);
    end
    checks++;
    if ({dec_cause, dec_exception, dec_encoded, dec_imm, dec_class} !== '0) begin
      failures++;
      $display("FAIL reset_data got cause=%0d exc=%b enc=%h imm=%h want all zero", dec_cause, dec_exception, dec_encoded, dec_imm);
    end
    @(negedge g_clk);
    g_resetn = 1'b1;
    step();
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got dec_valid=%b want 0", dec_valid);
    end
  endtask

  // add.px, pw=0, mid=15'h1234 -> encoding 32'h00091A2B
  task automatic test_single_pass();
    mccr = 8'hFF;
    dec_ready = 1'b1;
    cpu_insn_req_valid = 1'b1;
    cpu_insn_req_encoded = 32'h00091A2B;
    step();
    cpu_insn_req_valid = 1'b0;
    checks++;
    if ({dec_valid, fifo_count} !== {1'b0, 2'd1}) begin
      failures++;
      $display("FAIL single_latency got valid=%b count=%0d want 0 1", dec_valid, fifo_count);
    end
    step();
    $display("tx single enc=%h valid=%b class=%0d cause=%0d", dec_encoded, dec_valid, dec_class, dec_cause);
    checks++;
    if ({dec_valid, dec_class, dec_subclass, dec_pw} !== {1'b1, 3'd0, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL single_class got valid=%b class=%0d sub=%0d pw=%0d want 1 0 0 0", dec_valid, dec_class, dec_subclass, dec_pw);
    end
    checks++;
    if ({dec_cause, dec_exception} !== 3'b000) begin
      failures++;
      $display("FAIL single_cause got cause=%0d exc=%b want 0 0", dec_cause, dec_exception);
    end
    checks++;
    if (dec_encoded !== 32'h00091A2B) begin
      failures++;
      $display("FAIL single_encoded got %h want 00091a2b", dec_encoded);
    end
    checks++;
    if ({dec_crd, dec_rd, dec_rs1, dec_crs1, dec_crs2} !== {4'd4, 5'd20, 5'd18, 4'd2, 4'd1}) begin
      failures++;
      $display("FAIL single_regs got crd=%0d rd=%0d rs1=%0d crs1=%0d crs2=%0d want 4 20 18 2 1", dec_crd, dec_rd, dec_rs1, dec_crs1, dec_crs2);
    end
    checks++;
    if (dec_imm !== 32'd36) begin
      failures++;
      $display("FAIL single_imm got %h want 00000024", dec_imm);
    end
    step();
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got dec_valid=%b want 0", dec_valid);
    end
  endtask

  task automatic run_one(input logic [31:0] enc, input logic [7:0] m,
                         input logic [1:0] exp_cause, input string name);
    dec_ready = 1'b1;
    mccr = m;
    cpu_insn_req_valid = 1'b1;
    cpu_insn_req_encoded = enc;
    step();
    cpu_insn_req_valid = 1'b0;
    step();
    $display("tx %s enc=%h mccr=%h valid=%b cause=%0d", name, enc, m, dec_valid, dec_cause);
    checks++;
    if ({dec_valid, dec_cause, dec_exception} !== {1'b1, exp_cause, exp_cause != 2'd0}) begin
      failures++;
      $display("FAIL %s got valid=%b cause=%0d exc=%b want 1 %0d %b", name, dec_valid, dec_cause, dec_exception, exp_cause, exp_cause != 2'd0);
    end
    step();
    mccr = 8'hFF;
  endtask

  task automatic test_feature_gating();
    run_one(mk(3'd5, 4'd0, 3'd0, 15'h0),   8'hFD, 2'd2, "mp_disabled");
    run_one(mk(3'd5, 4'd0, 3'd0, 15'h0),   8'hFF, 2'd0, "mp_enabled");
    run_one(mk(3'd0, 4'd0, 3'd1, 15'h0),   8'hEF, 2'd3, "p16_disabled");
    run_one(mk(3'd0, 4'd0, 3'd1, 15'h0),   8'hFF, 2'd0, "p16_enabled");
    run_one(mk(3'd0, 4'd0, 3'd5, 15'h0),   8'hFF, 2'd3, "pw5_reserved");
    run_one(mk(3'd0, 4'd1, 3'd4, 15'h0),   8'h7F, 2'd3, "p2_disabled");
    run_one(mk(3'd3, 4'd0, 3'd0, 15'h0),   8'hFE, 2'd2, "rand_disabled");
    run_one(mk(3'd2, 4'd6, 3'd0, 15'h0),   8'hFB, 2'd2, "scatter_disabled");
    run_one(mk(3'd2, 4'd0, 3'd0, 15'h0),   8'hFB, 2'd0, "plain_load_sg_off");
    run_one(mk(3'd1, 4'd0, 3'd5, 15'h0),   8'h00, 2'd0, "twiddle_ungated");
  endtask

  task automatic test_bad_opcode();
    run_one(32'h0000_0000,               8'h00, 2'd1, "zero_enc_prio");
    run_one(mk(3'd7, 4'd0, 3'd0, 15'h0), 8'hFF, 2'd1, "class7");
    run_one(mk(3'd0, 4'd5, 3'd0, 15'h0), 8'hFF, 2'd1, "packed_sub5");
  endtask

  // mccr is captured at load; later changes must not alter a held output.
  task automatic test_mccr_sample();
    dec_ready = 1'b0;
    mccr = 8'hFF;
    cpu_insn_req_valid = 1'b1;
    cpu_insn_req_encoded = mk(3'd5, 4'd2, 3'd0, 15'h0);
    step();
    cpu_insn_req_valid = 1'b0;
    step();
    mccr = 8'h00;
    step();
    checks++;
    if ({dec_valid, dec_cause, dec_subclass} !== {1'b1, 2'd0, 4'd2}) begin
      failures++;
      $display("FAIL mccr_hold got valid=%b cause=%0d sub=%0d want 1 0 2", dec_valid, dec_cause, dec_subclass);
    end
    dec_ready = 1'b1;
    step();
    mccr = 8'hFF;
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL mccr_drain got dec_valid=%b want 0", dec_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vec [4];
    int accepted;
    logic acc;
    vec[0] = mk(3'd6, 4'd1, 3'd0, 15'h0011);
    vec[1] = mk(3'd6, 4'd2, 3'd0, 15'h0022);
    vec[2] = mk(3'd6, 4'd3, 3'd0, 15'h0033);
    vec[3] = mk(3'd6, 4'd4, 3'd0, 15'h0044);
    accepted = 0;
    dec_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (accepted < 4) begin
        cpu_insn_req_valid = 1'b1;
        cpu_insn_req_encoded = vec[accepted];
        acc = cpu_insn_req_ready;
        step();
        if (acc) accepted++;
      end
    end
    cpu_insn_req_valid = 1'b0;
    checks++;
    if (accepted !== 3) begin
      failures++;
      $display("FAIL bp_accepted got %0d want 3", accepted);
    end
    checks++;
    if ({cpu_insn_req_ready, fifo_count, dec_valid} !== {1'b0, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL bp_full got ready=%b count=%0d valid=%b want 0 2 1", cpu_insn_req_ready, fifo_count, dec_valid);
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      $display("tx bp_out%0d enc=%h valid=%b", k, dec_encoded, dec_valid);
      checks++;
      if ({dec_valid, dec_encoded} !== {1'b1, vec[k]}) begin
        failures++;
        $display("FAIL bp_order%0d got valid=%b enc=%h want 1 %h", k, dec_valid, dec_encoded, vec[k]);
      end
      step();
    end
    checks++;
    if ({dec_valid, fifo_count} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL bp_empty got valid=%b count=%0d want 0 0", dec_valid, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [4];
    for (int i = 0; i < 4; i++) vec[i] = mk(3'd4, 4'(i), 3'd0, 15'(i * 3 + 1));
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        cpu_insn_req_valid = 1'b1;
        cpu_insn_req_encoded = vec[i];
      end else begin
        cpu_insn_req_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        $display("tx b2b%0d enc=%h valid=%b", i - 1, dec_encoded, dec_valid);
        checks++;
        if ({dec_valid, dec_encoded, cpu_insn_req_ready} !== {1'b1, vec[i-1], 1'b1}) begin
          failures++;
          $display("FAIL b2b%0d got valid=%b enc=%h ready=%b want 1 %h 1", i - 1, dec_valid, dec_encoded, cpu_insn_req_ready, vec[i-1]);
        end
      end
    end
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got dec_valid=%b want 0", dec_valid);
    end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_insn_req_valid = 1'b1;
      cpu_insn_req_encoded = mk(3'd1, 4'(i), 3'd0, 15'h0);
      step();
    end
    checks++;
    if ({fifo_count, dec_valid} !== {2'd2, 1'b1}) begin
      failures++;
      $display("FAIL flush_setup got count=%0d valid=%b want 2 1", fifo_count, dec_valid);
    end
    cpu_insn_req_encoded = mk(3'd1, 4'd3, 3'd0, 15'h7777);
    flush = 1'b1;
    step();
    flush = 1'b0;
    cpu_insn_req_valid = 1'b0;
    checks++;
    if ({dec_valid, fifo_count, cpu_insn_req_ready} !== {1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL flush_full got valid=%b count=%0d ready=%b want 0 0 1", dec_valid, fifo_count, cpu_insn_req_ready);
    end
    // Flush against an empty FIFO with an accepted push: the push is dropped.
    dec_ready = 1'b1;
    cpu_insn_req_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    cpu_insn_req_valid = 1'b0;
    checks++;
    if (fifo_count !== 2'd0) begin
      failures++;
      $display("FAIL flush_push_count got %0d want 0", fifo_count);
    end
    step();
    step();
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_push_ghost got dec_valid=%b enc=%h want 0", dec_valid, dec_encoded);
    end
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_insn_req_valid = 1'b1;
      cpu_insn_req_encoded = mk(3'd6, 4'(i + 5), 3'd0, 15'h1F1F);
      step();
    end
    cpu_insn_req_valid = 1'b0;
    checks++;
    if ({dec_valid, fifo_count} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL arst_setup got valid=%b count=%0d want 1 1", dec_valid, fifo_count);
    end
    #2;
    g_resetn = 1'b0;
    #1;
    checks++;
    if ({dec_valid, fifo_count, cpu_insn_req_ready, dec_encoded, dec_cause} !== {1'b0, 2'd0, 1'b1, 32'd0, 2'd0}) begin
      failures++;
      $display("FAIL arst_clear got valid=%b count=%0d ready=%b enc=%h cause=%0d want 0 0 1 0 0", dec_valid, fifo_count, cpu_insn_req_ready, dec_encoded, dec_cause);
    end
    #2;
    g_resetn = 1'b1;
    run_one(mk(3'd0, 4'd0, 3'd2, 15'h0), 8'hFF, 2'd0, "after_arst");
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_feature_gating();
    test_bad_opcode();
    test_mccr_sample();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scarv_cop_dec_stage.md
# scarv_cop_dec_stage

Registered, flow-controlled instruction-decode stage for the SCARV crypto ISE coprocessor. It sits between the CPU coprocessor request port and the COP execute stage. Raw 32-bit encodings are buffered in a parametrised FIFO, decoded at the FIFO head, and held in an output register under a valid/ready handshake. Unlike the combinational decoder, it gates exceptions by runtime feature enables (MCCR) and by pack width, and it supports pipeline flush.

## Interface
- `DEPTH`, 2: input FIFO entries; power of two, ≥2.
- `FEAT_MASK`, 8'hFF: compile-time feature mask, ANDed with `mccr`.
- `g_clk` in 1: clock; all state updates on the rising edge.
- `g_resetn` in 1: reset, asynchronous assert, active-low.
- `cpu_insn_req_valid` in 1: an instruction is offered.
- `cpu_insn_req_ready` out 1: the stage can accept an instruction.
- `cpu_insn_req_encoded` in 32: instruction encoding.
- `flush` in 1: discard all buffered and decoded state.
- `mccr` in 8: runtime feature enables. Bits are [0] R, [1] MP, [2] SG, [3] P32, [4] P16, [5] P8, [6] P4, [7] P2.
- `dec_valid` out 1: the output register holds a decoded instruction.
- `dec_ready` in 1: execute accepts the output.
- `dec_class` out 3, `dec_subclass` out 4, `dec_pw` out 3: instruction class, subclass, and pack width.
- `dec_crs1`, `dec_crs2`, `dec_crs3`, `dec_crd`, `dec_crd1`, `dec_crd2` out 4 each: COP register fields.
- `dec_rd`, `dec_rs1` out 5 each: GPR fields.
- `dec_imm` out 32: decoded immediate.
- `dec_wb_h`, `dec_wb_b` out 1 each: load/store halfword and byte index.
- `dec_exception` out 1: illegal instruction.
- `dec_cause` out 2: 0 none, 1 bad opcode, 2 class disabled, 3 pack width disabled.
- `dec_encoded` out 32: raw encoding, passed through.
- `fifo_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Push:** occurs when `cpu_insn_req_valid && cpu_insn_req_ready`. `cpu_insn_req_ready` = `fifo_count != DEPTH`, derived from registered state only.
- **Pop and load:** the FIFO head is decoded combinationally. It pops into the output register when the FIFO is non-empty and (`!dec_valid || dec_ready`).
- **Output register:**
  - With no pop and `dec_valid && dec_ready`, `dec_valid` clears.
  - With no pop and `dec_ready` low, all outputs hold.
- **Feature enable:** `en = FEAT_MASK & mccr`, sampled in the cycle the head is loaded. A later `mccr` change does not alter an instruction already in the output register.
- **Exception cause:** priority is bad opcode > class disabled > pack width.
  - *Class disabled:* random class with `en[0]`=0; MP class with `en[1]`=0; scatter/gather with `en[2]`=0.
  - *Pack width:* applies to the packed-arith class only. Encoding is `dec_pw` 0→P32 (`en[3]`), 1→P16 (`en[4]`), 2→P8 (`en[5]`), 3→P4 (`en[6]`), 4→P2 (`en[7]`). Values 5–7 are cause 3 unconditionally.
  - `dec_exception` = (`dec_cause` != 0).
  - Excepting instructions still flow through the handshake. Their decoded fields hold whatever was decoded.
- **Flush:** on the next edge the FIFO empties, `fifo_count`=0 and `dec_valid`=0. A push or load in the same cycle is discarded. `cpu_insn_req_ready` is 1 in the following cycle.
- **Simultaneous push and pop:** when the FIFO is non-empty, push and pop in the same cycle leave the count unchanged.
- **Pointers:** wrap modulo `DEPTH`.

## Timing
- **Reset:** `fifo_count`=0, `cpu_insn_req_ready`=1 (combinationally, once reset is applied), `dec_valid`=0. All data outputs, `dec_exception` and `dec_cause` are 0.
- **Latency:** an instruction accepted at edge N appears with `dec_valid`=1 after edge N+1. There is no bypass.
- **Throughput:** 1 instruction/cycle when `dec_ready` is held high.
- **Stall:** with `dec_ready` held low, `DEPTH`+1 instructions are held. `cpu_insn_req_ready` falls after the `DEPTH`-th push into the FIFO.
- **Reset mid-operation:** asynchronous clear to the reset values; in-flight instructions are lost.

## Structure
- **Shared package `scarv_cop_pkg`:**
  - class and subclass constants;
  - MCCR bit indices;
  - pack-width codes;
  - cause codes (`SCARV_COP_CAUSE_*`).
- **Sub-module:** the existing combinational `scarv_cop_idecode`, instantiated once on the FIFO head.
- **FIFO:** inline, as registers plus read/write pointers. No separate module is needed.

## Test plan
- **Reset and single pass:** reset, then push one `add.px` with pw=0 and `mccr`=8'hFF → `dec_valid`=1 two edges later, `dec_class`=PACKED_ARITH, `dec_cause`=0.
- **Backpressure, `DEPTH`=2:** hold `dec_ready`=0 and offer 4 instructions → 3 accepted, ready low after the 2nd FIFO push. Release → outputs appear in order, one per cycle, with no loss or duplication.
- **Feature gating:** `mccr`=8'hFD with an MP instruction → cause 2. `mccr`=8'hEF with a packed add at pw=1 → cause 3. pw=5 → cause 3 even with `mccr`=8'hFF.
- **Bad opcode:** encoding 32'h0000_0000 → cause 1, which takes priority over disabled features.
- **Flush:** FIFO holding 2 instructions and the output valid, assert `flush` together with a push → next cycle `dec_valid`=0, `fifo_count`=0, and the pushed instruction never appears.
- **Async reset:** assert `g_resetn`=0 mid-stream between edges → outputs go to reset values immediately, and streaming resumes cleanly after deassert.
